// File: rtl/dcmmb_pkg.sv
// Purpose: shared widths, codeword geometry and FSM encoding for the bidin->LDPC fetch path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcmmb_pkg;

    localparam int WID      = 6;      // soft-value width, matches bidin
    localparam int CW_LEN   = 9216;   // symbols per LDPC codeword
    localparam int AW       = 14;     // symbol address width, 2^AW >= CW_LEN
    localparam int CW_NUM_W = 6;      // codeword-per-frame counter width

    // Fetch FSM encoding.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_RECV     = 3'd2,
        ST_WAIT_BUF = 3'd3,
        ST_FIN      = 3'd4,
        ST_DRAIN    = 3'd5
    } fsm_state_t;

    // Index of one of the two ping-pong buffer banks.
    typedef logic bank_t;

endpackage

// File: rtl/ldpc_bank_ctl.sv
// Purpose: ping-pong bank bookkeeping (full bits, write/read pointers) between fetch and decoder.
// Latency: fill/cw_done take effect on the next clock; cw_valid/cw_bank decode the registered state.
// Backpressure: a bank is reported full until the decoder's cw_done frees it; cw_done on an empty bank is ignored.
module ldpc_bank_ctl
    import dcmmb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       fill_i,       // last symbol of a codeword written into bank wr_bank_o
    input  logic       cw_done_i,    // decoder finished with bank cw_bank_o
    output logic [1:0] bank_full_o,
    output bank_t      wr_bank_o,
    output logic       cw_valid_o,
    output bank_t      cw_bank_o
);

    logic [1:0] bank_full_q, bank_full_d;
    bank_t      wr_bank_q, wr_bank_d;
    bank_t      rd_bank_q, rd_bank_d;
    logic       done_ok;

    // Only a release of a bank that actually holds a codeword counts.
    assign done_ok = cw_done_i & bank_full_q[rd_bank_q];

    // Fill and release act on different banks, so both may apply in one cycle.
    always_comb begin
        bank_full_d = bank_full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        if (fill_i) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
        end
        if (done_ok) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end
    end

    // Bank state registers, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bank_full_q <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
        end else begin
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
        end
    end

    assign bank_full_o = bank_full_q;
    assign wr_bank_o   = wr_bank_q;
    assign cw_valid_o  = bank_full_q[rd_bank_q];
    assign cw_bank_o   = rd_bank_q;

endmodule

// File: rtl/ldpc_fetch.sv
// Purpose: requests codewords from bidin and captures each burst into a two-bank LDPC input buffer.
// Latency: buffer write (llr_wr/addr/data) is registered, one cycle after the bidin strobe.
// Backpressure: no new ldpc_req while the target bank is still full; fetch stalls until cw_done frees it.
module ldpc_fetch
    import dcmmb_pkg::*;
(
    input  logic                clk6,
    input  logic                rst,
    input  logic [CW_NUM_W-1:0] cw_num,
    input  logic                bidin_rdy,
    input  logic                bidin_ena_out,
    input  logic [WID-1:0]      bidin_dout,
    output logic                ldpc_req,
    output logic                ldpc_fin,
    output logic                llr_wr,
    output logic [AW:0]         llr_addr,
    output logic [WID-1:0]      llr_data,
    output logic                cw_valid,
    output logic                cw_bank,
    input  logic                cw_done,
    output logic                err_unexp
);

    localparam logic [AW-1:0] SYM_LAST = AW'(CW_LEN - 1);

    fsm_state_t          state_q, state_d;
    logic [AW-1:0]       sym_cnt_q, sym_cnt_d;
    logic [CW_NUM_W-1:0] cw_cnt_q, cw_cnt_d;
    logic [CW_NUM_W-1:0] cw_tot_q, cw_tot_d;
    logic                wr_q, wr_d;
    logic [AW:0]         addr_q, addr_d;
    logic [WID-1:0]      data_q, data_d;
    logic                err_q, err_d;
    logic                req, fin, fill;

    logic [1:0]          bank_full;
    bank_t               wr_bank;
    bank_t               rd_bank;

    ldpc_bank_ctl u_bank_ctl (
        .clk_i       (clk6),
        .rst_i       (rst),
        .fill_i      (fill),
        .cw_done_i   (cw_done),
        .bank_full_o (bank_full),
        .wr_bank_o   (wr_bank),
        .cw_valid_o  (cw_valid),
        .cw_bank_o   (rd_bank)
    );

    // Fetch FSM next state, symbol/codeword counting and buffer write generation.
    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        cw_cnt_d  = cw_cnt_q;
        cw_tot_d  = cw_tot_q;
        wr_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        req       = 1'b0;
        fin       = 1'b0;
        fill      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bidin_rdy) begin
                    cw_tot_d = cw_num;
                    if (cw_num == '0)
                        state_d = ST_FIN;
                    else if (!bank_full[wr_bank])
                        state_d = ST_REQ;
                    else
                        state_d = ST_WAIT_BUF;
                end
            end
            ST_REQ: begin
                req       = 1'b1;
                sym_cnt_d = '0;
                state_d   = ST_RECV;
            end
            ST_RECV: begin
                if (bidin_ena_out) begin
                    wr_d   = 1'b1;
                    addr_d = {wr_bank, sym_cnt_q};
                    data_d = bidin_dout;
                    if (sym_cnt_q == SYM_LAST) begin
                        sym_cnt_d = '0;
                        fill      = 1'b1;
                        cw_cnt_d  = cw_cnt_q + 1'b1;
                        if (cw_cnt_q == cw_tot_q - 1'b1)
                            state_d = ST_FIN;
                        else
                            state_d = ST_WAIT_BUF;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT_BUF: begin
                if (!bank_full[wr_bank])
                    state_d = ST_REQ;
            end
            ST_FIN: begin
                fin      = 1'b1;
                cw_cnt_d = '0;
                state_d  = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Hold until bidin drops rdy so the same frame is not fetched twice.
                if (!bidin_rdy)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A strobe outside RECV is a protocol error that sticks until reset.
    always_comb begin
        err_d = err_q | (bidin_ena_out & (state_q != ST_RECV));
    end

    // State, counters, registered buffer write port and error flag.
    always_ff @(posedge clk6) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sym_cnt_q <= '0;
            cw_cnt_q  <= '0;
            cw_tot_q  <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            cw_cnt_q  <= cw_cnt_d;
            cw_tot_q  <= cw_tot_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    assign ldpc_req  = req;
    assign ldpc_fin  = fin;
    assign llr_wr    = wr_q;
    assign llr_addr  = addr_q;
    assign llr_data  = data_q;
    assign cw_bank   = rd_bank;
    assign err_unexp = err_q;

endmodule

// File: tb/tb_ldpc_fetch.sv
// Purpose: self-checking bench for ldpc_fetch (frame table, backpressure, stray strobes, mid-burst reset).
// Latency: expects buffer writes one cycle after each strobe; outputs sampled on the falling edge.
// Backpressure: models the decoder by pulsing cw_done explicitly from the stimulus.
module tb_ldpc_fetch;
    import dcmmb_pkg::*;

    logic                clk6 = 1'b0;
    logic                rst;
    logic [CW_NUM_W-1:0] cw_num;
    logic                bidin_rdy;
    logic                bidin_ena_out;
    logic [WID-1:0]      bidin_dout;
    logic                ldpc_req;
    logic                ldpc_fin;
    logic                llr_wr;
    logic [AW:0]         llr_addr;
    logic [WID-1:0]      llr_data;
    logic                cw_valid;
    logic                cw_bank;
    logic                cw_done;
    logic                err_unexp;

    always #5 clk6 = ~clk6;

    ldpc_fetch dut (
        .clk6          (clk6),
        .rst           (rst),
        .cw_num        (cw_num),
        .bidin_rdy     (bidin_rdy),
        .bidin_ena_out (bidin_ena_out),
        .bidin_dout    (bidin_dout),
        .ldpc_req      (ldpc_req),
        .ldpc_fin      (ldpc_fin),
        .llr_wr        (llr_wr),
        .llr_addr      (llr_addr),
        .llr_data      (llr_data),
        .cw_valid      (cw_valid),
        .cw_bank       (cw_bank),
        .cw_done       (cw_done),
        .err_unexp     (err_unexp)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_req = 0;
    int n_fin = 0;
    int n_wr  = 0;
    int seq   = 0;
    bit exp_bank = 1'b0;

    // Expected buffer writes: {bank, symbol index, data}.
    logic [AW+WID:0] exp_q[$];

    typedef struct {
        logic [CW_NUM_W-1:0] num;
        int                  period;
        bit                  done_last;
        int                  exp_req;
        int                  exp_fin;
        bit                  exp_valid;
        bit                  exp_cwbank;
    } vec_t;

    vec_t tbl[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: count pulses and compare every buffer write against the queue.
    always @(negedge clk6) begin
        if (ldpc_req === 1'b1) n_req++;
        if (ldpc_fin === 1'b1) n_fin++;
        if (llr_wr === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_wr: got addr 0x%0h data 0x%0h, want no write", llr_addr, llr_data);
            end else begin
                check("wr_addr_data", 32'({llr_addr, llr_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [31:0] all_outs();
        return 32'({ldpc_req, ldpc_fin, llr_wr, llr_addr, llr_data, cw_valid, cw_bank, err_unexp});
    endfunction

    task automatic wait_req(input int budget, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (ldpc_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk6);
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_fin(input int budget, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (ldpc_fin === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk6);
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // Stream n_sym strobes, one every 'period' cycles; optionally cw_done on the last one.
    task automatic stream_cw(input int period, input bit done_last, input int n_sym);
        int w0 = n_wr;
        int f0 = n_fin;
        for (int i = 0; i < n_sym; i++) begin
            if (i > 0) begin
                for (int g = 1; g < period; g++) begin
                    @(negedge clk6);
                    bidin_ena_out = 1'b0;
                end
            end
            @(negedge clk6);
            if (period > 1 && i == n_sym - 1) begin
                check("gap_wr_count_before_last", 32'(n_wr - w0), 32'(n_sym - 1));
                check("gap_no_early_fin", 32'(n_fin), 32'(f0));
            end
            bidin_ena_out = 1'b1;
            bidin_dout    = WID'(i + seq);
            cw_done       = done_last && (i == n_sym - 1);
            exp_q.push_back({exp_bank, AW'(i), WID'(i + seq)});
        end
        @(negedge clk6);
        bidin_ena_out = 1'b0;
        cw_done       = 1'b0;
        if (n_sym == CW_LEN) begin
            exp_bank = ~exp_bank;
            seq      = seq + 7;
        end
    endtask

    task automatic pulse_done();
        @(negedge clk6);
        cw_done = 1'b1;
        @(negedge clk6);
        cw_done = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        int r0, f0, w0;

        tbl[0] = '{6'd1, 1, 1'b0, 1, 1, 1'b1, 1'b0};   // single codeword into bank 0
        tbl[1] = '{6'd0, 1, 1'b0, 0, 1, 1'b1, 1'b0};   // empty frame: fin only
        tbl[2] = '{6'd1, 1, 1'b1, 1, 1, 1'b1, 1'b1};   // bank 1 fill with cw_done on bank 0 same cycle

        rst = 1'b1; cw_num = '0; bidin_rdy = 1'b0; bidin_ena_out = 1'b0;
        bidin_dout = '0; cw_done = 1'b0;
        repeat (3) @(negedge clk6);
        check("reset_outputs", all_outs(), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk6);

        for (int v = 0; v < 3; v++) begin
            r0 = n_req; f0 = n_fin; w0 = n_wr;
            cw_num    = tbl[v].num;
            bidin_rdy = 1'b1;
            for (int c = 0; c < int'(tbl[v].num); c++) begin
                wait_req(4, "tbl_req_seen");
                stream_cw(tbl[v].period, tbl[v].done_last, CW_LEN);
            end
            wait_fin(4, "tbl_fin_seen");
            repeat (6) @(negedge clk6);
            check("tbl_req_count", 32'(n_req - r0), 32'(tbl[v].exp_req));
            check("tbl_fin_count", 32'(n_fin - f0), 32'(tbl[v].exp_fin));
            check("tbl_wr_count", 32'(n_wr - w0), 32'(int'(tbl[v].num) * CW_LEN));
            check("tbl_cw_valid", 32'(cw_valid), 32'(tbl[v].exp_valid));
            check("tbl_cw_bank", 32'(cw_bank), 32'(tbl[v].exp_cwbank));
            check("tbl_queue_empty", 32'(exp_q.size()), 32'd0);
            bidin_rdy = 1'b0;
            repeat (3) @(negedge clk6);
        end

        // Release bank 1; the following cw_done arrives with nothing valid and must be ignored.
        pulse_done();
        check("valid_after_done", 32'(cw_valid), 32'd0);
        check("bank_after_done", 32'(cw_bank), 32'd0);
        pulse_done();
        check("ignored_done_bank", 32'(cw_bank), 32'd0);
        check("ignored_done_valid", 32'(cw_valid), 32'd0);

        // Backpressure: three codewords, decoder withholds cw_done until both banks are full.
        r0 = n_req; f0 = n_fin; w0 = n_wr;
        cw_num = 6'd3; bidin_rdy = 1'b1;
        wait_req(4, "bp_req1");
        stream_cw(1, 1'b0, CW_LEN);
        wait_req(4, "bp_req2");
        stream_cw(1, 1'b0, CW_LEN);
        repeat (20) @(negedge clk6);
        check("bp_stall_req_count", 32'(n_req - r0), 32'd2);
        check("bp_stall_valid", 32'(cw_valid), 32'd1);
        check("bp_stall_bank", 32'(cw_bank), 32'd0);
        check("bp_stall_fin", 32'(n_fin - f0), 32'd0);
        cw_done = 1'b1;
        @(negedge clk6);
        cw_done = 1'b0;
        wait_req(2, "bp_req3_after_done");
        stream_cw(3, 1'b0, CW_LEN);            // gapped third codeword, reuses bank 0
        wait_fin(4, "bp_fin_seen");
        repeat (4) @(negedge clk6);
        check("bp_req_count", 32'(n_req - r0), 32'd3);
        check("bp_fin_count", 32'(n_fin - f0), 32'd1);
        check("bp_wr_count", 32'(n_wr - w0), 32'(3 * CW_LEN));
        check("bp_cw_bank", 32'(cw_bank), 32'd1);
        bidin_rdy = 1'b0;
        pulse_done();
        check("bp_drain1_valid", 32'(cw_valid), 32'd1);
        check("bp_drain1_bank", 32'(cw_bank), 32'd0);
        pulse_done();
        check("bp_drain2_valid", 32'(cw_valid), 32'd0);

        // Stray strobes in IDLE.
        w0 = n_wr;
        check("err_before_stray", 32'(err_unexp), 32'd0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk6);
            bidin_ena_out = 1'b1;
            bidin_dout    = WID'(s);
        end
        @(negedge clk6);
        bidin_ena_out = 1'b0;
        repeat (10) @(negedge clk6);
        check("stray_no_write", 32'(n_wr - w0), 32'd0);
        check("stray_err_sticky", 32'(err_unexp), 32'd1);

        // Reset after 4000 symbols of a burst; a fresh fetch must restart at bank 0, address 0.
        cw_num = 6'd1; bidin_rdy = 1'b1;
        wait_req(4, "rst_req_seen");
        stream_cw(1, 1'b0, 4000);
        rst = 1'b1;
        @(negedge clk6);
        check("rst_mid_outputs", all_outs(), 32'd0);
        check("rst_mid_queue_empty", 32'(exp_q.size()), 32'd0);
        rst = 1'b0;
        exp_bank = 1'b0;
        w0 = n_wr;
        wait_req(4, "rst_fresh_req");
        stream_cw(1, 1'b0, 16);
        repeat (3) @(negedge clk6);
        check("rst_fresh_wr_count", 32'(n_wr - w0), 32'd16);
        check("rst_fresh_queue_empty", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
